// File: rtl/arb_pkg.sv
// rtl/arb_pkg.sv - shared types, defaults and sizing helper for the link arbiter
package arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        RELEASE = 2'd2
    } arb_state_t;

    localparam int DEF_N_REQ       = 4;
    localparam int DEF_MAX_HOLD    = 50_000_000;
    localparam int DEF_GAP_CYCLES  = 4;
    localparam int DEF_SYNC_STAGES = 2;

    function automatic int clog2(input int value);
        int bits;
        int rem;
        bits = 0;
        rem  = value - 1;
        while (rem > 0) begin
            bits++;
            rem = rem >> 1;
        end
        return bits;
    endfunction

endpackage

// File: rtl/req_sync.sv
// rtl/req_sync.sv - multi-stage synchronizer whose flops reset to 1 (request idle)
module req_sync #(
    parameter int WIDTH  = 1,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] chain [STAGES];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < STAGES; i++) chain[i] <= '1;
        end else begin
            chain[0] <= d;
            for (int i = 1; i < STAGES; i++) chain[i] <= chain[i-1];
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/link_round_robin_arbiter.sv
// rtl/link_round_robin_arbiter.sv - round-robin arbiter for a shared resource with hold timeout and release guard gap
module link_round_robin_arbiter
    import arb_pkg::*;
#(
    parameter int N_REQ       = DEF_N_REQ,
    parameter int MAX_HOLD    = DEF_MAX_HOLD,
    parameter int GAP_CYCLES  = DEF_GAP_CYCLES,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic                      clk_clk,
    input  logic                      reset_reset_n,
    input  logic [N_REQ-1:0]          req_n,
    output logic [N_REQ-1:0]          grant,
    output logic [clog2(N_REQ)-1:0]   owner,
    output logic                      busy,
    output logic                      timeout_pulse
);

    localparam int OW = clog2(N_REQ);
    localparam int HW = (clog2(MAX_HOLD) < 1) ? 1 : clog2(MAX_HOLD);
    localparam int GW = clog2(GAP_CYCLES + 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);
    localparam logic [GW-1:0] GAP_LAST  = GW'(GAP_CYCLES - 1);

    logic [N_REQ-1:0] req_n_sync;
    logic [N_REQ-1:0] req;
    logic [N_REQ-1:0] req_eff;
    logic [N_REQ-1:0] lockout;
    arb_state_t       state;
    logic [HW-1:0]    hold_cnt;
    logic [GW-1:0]    gap_cnt;
    logic [OW-1:0]    rr_start;
    logic [OW:0]      pick;
    logic             owner_req;

    req_sync #(
        .WIDTH  (N_REQ),
        .STAGES (SYNC_STAGES)
    ) u_req_sync (
        .clk   (clk_clk),
        .rst_n (reset_reset_n),
        .d     (req_n),
        .q     (req_n_sync)
    );

    assign req       = ~req_n_sync;
    assign req_eff   = req & ~lockout;
    assign owner_req = req[owner];

    // Returns {found, index}; scanning backwards lets the earliest hit in circular order win.
    function automatic logic [OW:0] rr_pick(input logic [N_REQ-1:0] vec, input logic [OW-1:0] start);
        logic [OW:0] res;
        int          idx;
        res = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            idx = (int'(start) + i) % N_REQ;
            if (vec[idx]) res = {1'b1, OW'(idx)};
        end
        return res;
    endfunction

    assign pick = rr_pick(req_eff, rr_start);

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state         <= IDLE;
            owner         <= '0;
            rr_start      <= '0;
            hold_cnt      <= '0;
            gap_cnt       <= '0;
            lockout       <= '0;
            grant         <= '0;
            busy          <= 1'b0;
            timeout_pulse <= 1'b0;
        end else begin
            timeout_pulse <= 1'b0;
            // A locked-out node is forgiven once its synced request has dropped.
            lockout       <= lockout & req;
            case (state)
                IDLE: begin
                    if (pick[OW]) begin
                        owner    <= pick[OW-1:0];
                        rr_start <= (int'(pick[OW-1:0]) == N_REQ - 1) ? '0 : pick[OW-1:0] + OW'(1);
                        hold_cnt <= '0;
                        grant    <= N_REQ'(1) << pick[OW-1:0];
                        busy     <= 1'b1;
                        state    <= GRANT;
                    end
                end
                GRANT: begin
                    hold_cnt <= hold_cnt + HW'(1);
                    if (!owner_req || hold_cnt == HOLD_LAST) begin
                        grant   <= '0;
                        busy    <= 1'b0;
                        gap_cnt <= '0;
                        state   <= RELEASE;
                        if (owner_req) begin
                            lockout[owner] <= 1'b1;
                            timeout_pulse  <= 1'b1;
                        end
                    end
                end
                RELEASE: begin
                    gap_cnt <= gap_cnt + GW'(1);
                    if (gap_cnt == GAP_LAST) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_link_round_robin_arbiter.sv
// tb/tb_link_round_robin_arbiter.sv - self-checking bench for link_round_robin_arbiter
module tb_link_round_robin_arbiter;

    localparam int N    = 4;
    localparam int MAXH = 16;
    localparam int GAP  = 4;
    localparam int SYNC = 2;

    logic         clk   = 1'b0;
    logic         rst_n = 1'b0;
    logic [N-1:0] req_n = '1;
    logic [N-1:0] grant;
    logic [1:0]   owner;
    logic         busy;
    logic         timeout_pulse;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    link_round_robin_arbiter #(
        .N_REQ       (N),
        .MAX_HOLD    (MAXH),
        .GAP_CYCLES  (GAP),
        .SYNC_STAGES (SYNC)
    ) dut (
        .clk_clk       (clk),
        .reset_reset_n (rst_n),
        .req_n         (req_n),
        .grant         (grant),
        .owner         (owner),
        .busy          (busy),
        .timeout_pulse (timeout_pulse)
    );

    // Reference model: phase 0 = nobody holds, 1 = someone holds, 2 = guard gap.
    logic [N-1:0] sync_q [SYNC];
    int           m_phase, m_own, m_start, m_held, m_guard;
    logic [N-1:0] m_lock;
    logic [N-1:0] m_grant;
    logic [1:0]   m_owner;
    logic         m_busy, m_pulse;

    task automatic model_reset();
        for (int s = 0; s < SYNC; s++) sync_q[s] = '1;
        m_phase = 0; m_own = 0; m_start = 0; m_held = 0; m_guard = 0;
        m_lock = '0; m_grant = '0; m_owner = 2'd0; m_busy = 1'b0; m_pulse = 1'b0;
    endtask

    task automatic model_step();
        logic [N-1:0] rq;
        logic [N-1:0] lock_next;
        int           pick;
        rq        = ~sync_q[SYNC-1];
        lock_next = m_lock & rq;
        m_pulse   = 1'b0;
        if (m_phase == 0) begin
            pick = -1;
            for (int k = 0; k < N; k++)
                if (pick < 0 && rq[(m_start + k) % N] && !m_lock[(m_start + k) % N]) pick = (m_start + k) % N;
            if (pick >= 0) begin
                m_own = pick; m_start = (pick + 1) % N; m_held = 0; m_phase = 1;
            end
        end else if (m_phase == 1) begin
            m_held++;
            if (!rq[m_own]) begin
                m_phase = 2; m_guard = GAP;
            end else if (m_held == MAXH) begin
                m_phase = 2; m_guard = GAP; lock_next[m_own] = 1'b1; m_pulse = 1'b1;
            end
        end else begin
            m_guard--;
            if (m_guard == 0) m_phase = 0;
        end
        m_lock = lock_next;
        for (int s = SYNC - 1; s > 0; s--) sync_q[s] = sync_q[s-1];
        sync_q[0] = req_n;
        m_grant = (m_phase == 1) ? (N'(1) << m_own) : '0;
        m_owner = 2'(m_own);
        m_busy  = (m_phase == 1);
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) model_reset();
        else        model_step();
    end

    // Grant-start order and timeout pulse tally, observed from the DUT.
    logic [N-1:0] prev_grant = '0;
    int           order[$];
    int           n_pulse = 0;

    always @(negedge clk) begin
        if (prev_grant == '0 && grant != '0)
            for (int i = 0; i < N; i++) if (grant[i]) order.push_back(i);
        prev_grant <= grant;
        if (timeout_pulse) n_pulse <= n_pulse + 1;
    end

    task automatic do_reset();
        req_n = '1;
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req_n = '1;
        repeat (3) @(negedge clk);
        vectors++; if (grant !== '0) begin miscompares++; $display("FAIL reset_grant got %b want 0000", grant); end
        vectors++; if (owner !== 2'd0) begin miscompares++; $display("FAIL reset_owner got %0d want 0", owner); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %b want 0", busy); end
        vectors++; if (timeout_pulse !== 1'b0) begin miscompares++; $display("FAIL reset_timeout got %b want 0", timeout_pulse); end
        rst_n = 1'b1;
    endtask

    task automatic test_first_grant();
        @(negedge clk);
        req_n = 4'b1110;
        repeat (2) @(negedge clk);
        vectors++; if (grant !== 4'b0000) begin miscompares++; $display("FAIL first_grant_early got %b want 0000", grant); end
        @(negedge clk);
        vectors++;
        if (grant !== 4'b0001 || owner !== 2'd0 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL first_grant got grant=%b owner=%0d busy=%b want grant=0001 owner=0 busy=1", grant, owner, busy);
        end
        req_n = '1;
        repeat (12) @(negedge clk);
    endtask

    task automatic test_alternate();
        int held[N];
        int exp_alt[4] = '{0, 2, 0, 2};
        bit again[N];
        int base;
        do_reset();
        for (int i = 0; i < N; i++) begin held[i] = 0; again[i] = 1'b0; end
        base  = order.size();
        req_n = 4'b1010;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            vectors++;
            if ({grant, owner, busy, timeout_pulse} !== {m_grant, m_owner, m_busy, m_pulse} || !$onehot0(grant)) begin
                miscompares++;
                $display("FAIL alternate_cycle t=%0t got %b/%0d/%b/%b want %b/%0d/%b/%b", $time,
                         grant, owner, busy, timeout_pulse, m_grant, m_owner, m_busy, m_pulse);
            end
            for (int i = 0; i < N; i += 2) begin
                held[i] = m_grant[i] ? held[i] + 1 : 0;
                if (again[i]) begin req_n[i] = 1'b0; again[i] = 1'b0; end
                else if (held[i] == 10) begin req_n[i] = 1'b1; again[i] = 1'b1; end
            end
        end
        for (int k = 0; k < 4; k++) begin
            vectors++;
            if (order.size() <= base + k || order[base + k] != exp_alt[k]) begin
                miscompares++;
                $display("FAIL alternate_order idx=%0d got %0d want %0d", k,
                         (order.size() > base + k) ? order[base + k] : -1, exp_alt[k]);
            end
        end
        req_n = '1;
    endtask

    task automatic test_wrap();
        int  held[N];
        int  base;
        bit  found;
        do_reset();
        req_n = 4'b0111;
        found = 1'b0;
        for (int c = 0; c < 40 && !found; c++) begin
            @(negedge clk);
            vectors++;
            if ({grant, owner, busy, timeout_pulse} !== {m_grant, m_owner, m_busy, m_pulse} || !$onehot0(grant)) begin
                miscompares++;
                $display("FAIL wrap_setup t=%0t got %b/%0d want %b/%0d", $time, grant, owner, m_grant, m_owner);
            end
            if (m_grant == 4'b1000) found = 1'b1;
        end
        vectors++; if (!found) begin miscompares++; $display("FAIL wrap_wait got no grant to node 3 want grant=1000"); end
        req_n = '1;
        repeat (15) @(negedge clk);
        vectors++; if (owner !== 2'd3) begin miscompares++; $display("FAIL wrap_owner got %0d want 3", owner); end
        for (int i = 0; i < N; i++) held[i] = 0;
        base  = order.size();
        req_n = 4'b0000;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            vectors++;
            if ({grant, owner, busy, timeout_pulse} !== {m_grant, m_owner, m_busy, m_pulse} || !$onehot0(grant)) begin
                miscompares++;
                $display("FAIL wrap_cycle t=%0t got %b/%0d/%b/%b want %b/%0d/%b/%b", $time,
                         grant, owner, busy, timeout_pulse, m_grant, m_owner, m_busy, m_pulse);
            end
            for (int i = 0; i < N; i++) begin
                held[i] = m_grant[i] ? held[i] + 1 : 0;
                if (held[i] == 3) req_n[i] = 1'b1;
            end
        end
        for (int k = 0; k < N; k++) begin
            vectors++;
            if (order.size() <= base + k || order[base + k] != k) begin
                miscompares++;
                $display("FAIL wrap_order idx=%0d got %0d want %0d", k, (order.size() > base + k) ? order[base + k] : -1, k);
            end
        end
        req_n = '1;
    endtask

    task automatic test_timeout();
        int hi;
        int base_p;
        do_reset();
        base_p = n_pulse;
        hi     = 0;
        req_n  = 4'b1101;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            vectors++;
            if ({grant, owner, busy, timeout_pulse} !== {m_grant, m_owner, m_busy, m_pulse} || !$onehot0(grant)) begin
                miscompares++;
                $display("FAIL timeout_cycle t=%0t got %b/%0d/%b/%b want %b/%0d/%b/%b", $time,
                         grant, owner, busy, timeout_pulse, m_grant, m_owner, m_busy, m_pulse);
            end
            if (grant[1]) hi++;
        end
        vectors++; if (hi != MAXH) begin miscompares++; $display("FAIL timeout_hold got %0d cycles want %0d", hi, MAXH); end
        vectors++; if (n_pulse - base_p != 1) begin miscompares++; $display("FAIL timeout_pulses got %0d want 1", n_pulse - base_p); end
        req_n = '1;
        repeat (3) @(negedge clk);
        req_n = 4'b1101;
        hi    = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (grant[1]) hi++;
        end
        vectors++; if (hi == 0) begin miscompares++; $display("FAIL timeout_regrant got 0 grant cycles want >0"); end
        req_n = '1;
    endtask

    task automatic test_terminal_release();
        int hi;
        int k;
        int base_p;
        do_reset();
        base_p = n_pulse;
        hi     = 0;
        k      = 0;
        req_n  = 4'b1101;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            vectors++;
            if ({grant, owner, busy, timeout_pulse} !== {m_grant, m_owner, m_busy, m_pulse} || !$onehot0(grant)) begin
                miscompares++;
                $display("FAIL terminal_cycle t=%0t got %b/%0d/%b/%b want %b/%0d/%b/%b", $time,
                         grant, owner, busy, timeout_pulse, m_grant, m_owner, m_busy, m_pulse);
            end
            if (grant[1]) hi++;
            if (m_grant[1]) k++;
            if (k == MAXH - 2) req_n[1] = 1'b1;
        end
        vectors++; if (hi != MAXH) begin miscompares++; $display("FAIL terminal_hold got %0d cycles want %0d", hi, MAXH); end
        vectors++; if (n_pulse != base_p) begin miscompares++; $display("FAIL terminal_pulse got %0d pulses want 0", n_pulse - base_p); end
        req_n = '1;
    endtask

    task automatic test_reset_mid_grant();
        int  base;
        bit  found;
        do_reset();
        req_n = 4'b1100;
        found = 1'b0;
        for (int c = 0; c < 20 && !found; c++) begin
            @(negedge clk);
            if (m_grant == 4'b0001) found = 1'b1;
        end
        vectors++; if (!found) begin miscompares++; $display("FAIL midreset_wait got no grant to node 0 want grant=0001"); end
        repeat (2) @(negedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if (grant !== '0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL midreset_async got grant=%b busy=%b want grant=0000 busy=0", grant, busy);
        end
        @(negedge clk);
        rst_n = 1'b1;
        base  = order.size();
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            vectors++;
            if ({grant, owner, busy, timeout_pulse} !== {m_grant, m_owner, m_busy, m_pulse} || !$onehot0(grant)) begin
                miscompares++;
                $display("FAIL midreset_cycle t=%0t got %b/%0d want %b/%0d", $time, grant, owner, m_grant, m_owner);
            end
        end
        vectors++;
        if (order.size() <= base || order[base] != 0) begin
            miscompares++;
            $display("FAIL midreset_restart got first grantee %0d want 0", (order.size() > base) ? order[base] : -1);
        end
        req_n = '1;
    endtask

    task automatic test_random();
        int rate[N] = '{6, 12, 25, 60};
        do_reset();
        for (int c = 0; c < 2000; c++) begin
            @(negedge clk);
            vectors++;
            if ({grant, owner, busy, timeout_pulse} !== {m_grant, m_owner, m_busy, m_pulse} || !$onehot0(grant)) begin
                miscompares++;
                $display("FAIL random_cycle t=%0t got %b/%0d/%b/%b want %b/%0d/%b/%b", $time,
                         grant, owner, busy, timeout_pulse, m_grant, m_owner, m_busy, m_pulse);
            end
            for (int i = 0; i < N; i++)
                if ($urandom_range(0, rate[i]) == 0) req_n[i] = ~req_n[i];
        end
        req_n = '1;
    endtask

    initial begin
        test_reset();
        test_first_grant();
        test_alternate();
        test_wrap();
        test_timeout();
        test_terminal_release();
        test_reset_mid_grant();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation exceeded time limit");
        $fatal(1);
    end

endmodule
